mmu_sram_responder: RTL and testbench
=====================================

// Module: mmu_sram_responder
// PURPOSE
//  Memory-side responder for the CU data-access request interface (memfetch_start/addr/bits_to_access/read_or_write).
//  Accepts one load/store at a time and services it from an internal word-wide SRAM with byte-lane enables.
//  Returns read data and completion/error status with programmable wait states.
//  Sits in the MMU between the CU memory stage and the SoC SRAM.
// PARAMETERS
//  DEPTH        1024          number of 32-bit words in the SRAM (power of two, >=2)
//  BASE_ADDR    32'h0000_0000 byte address of word 0; must be 4-byte aligned
//  WAIT_STATES  0             extra cycles in WAIT before response (0..15)
// PORTS
//  soc_clk         in   1   system clock, all state on rising edge
//  MMU_reset_n     in   1   asynchronous, active-low reset
//  memfetch_start  in   1   request strobe; sampled only in IDLE
//  addr            in   32  byte address; addr[1:0] must be 0
//  bits_to_access  in   4   byte-lane mask, bit i = byte lane i of the word
//  read_or_write   in   1   0 = read, 1 = write
//  wdata           in   32  write data, lanes in place; sampled with request
//  MEM_stall       in   1   requester cannot take response; hold it
//  mem_busy        out  1   high whenever state != IDLE
//  mem_done        out  1   response valid; held while MEM_stall
//  mem_err         out  1   qualifies mem_done: request rejected
//  MEM_data        out  32  read data; disabled lanes = 0
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): state=IDLE, all outputs 0, capture regs 0. SRAM contents not reset.
//  - FSM: IDLE -> WAIT on memfetch_start; WAIT -> RESP when wait counter == WAIT_STATES;
//    RESP -> IDLE on first cycle with MEM_stall=0 (mem_done seen high that cycle).
//  - Capture: in IDLE with memfetch_start=1, latch addr, mask, rw, wdata; counter cleared.
//  - Latency: start sampled at edge N -> mem_done high after edge N+1+WAIT_STATES.
//  - Starts while mem_busy=1 are ignored (not queued); requester must wait for mem_done.
//  - Legal masks: 0001,0010,0100,1000,0011,1100,1111. Anything else (incl. 0000) -> error.
//  - Error also when addr[1:0]!=0, addr<BASE_ADDR or addr>=BASE_ADDR+4*DEPTH.
//  - Error response: no SRAM write, MEM_data=0, mem_err=1 with mem_done; same latency as success.
//  - Word index = (addr-BASE_ADDR)>>2, width $clog2(DEPTH), computed in 32 bits, no wrap.
//  - Write: committed on WAIT->RESP edge, only enabled lanes updated; MEM_data=0 in response.
//  - Read: SRAM read on WAIT->RESP edge; MEM_data = word with disabled lanes zeroed, held stable through RESP.
//  - mem_done, mem_err, MEM_data registered; all return to 0 on RESP->IDLE edge.
//  - Reset mid-operation: abort; write not yet committed is dropped; committed write persists.
//  - Back-to-back: new start accepted in the IDLE cycle immediately after RESP exits (1 idle bubble min).
// STRUCTURE
//  - mmu_pkg: typedef enum {IDLE,WAIT,RESP} mmu_state_t; RW_READ/RW_WRITE consts; legal mask list;
//    function mask_legal(logic[3:0]).
//  - Sub-module mmu_sram_array: DEPTH x 32 sync-read/sync-write array, per-byte write enable, no reset.
//  - Top: capture regs, range/alignment check, wait counter, FSM, response regs.
// TESTING
//  1. Write 0xDEADBEEF mask 1111 @BASE+0x10, then read @0x10 mask 1111 -> MEM_data=0xDEADBEEF, mem_err=0.
//  2. Write 0x000000AA mask 0001 then 0x00BB0000 mask 0100 @0x10 -> full read 0xDEBBBEAA; read mask 1100 -> 0xDEBB0000.
//  3. WAIT_STATES=3: start at edge N -> mem_busy from N, mem_done first high after edge N+4; start at N+1 ignored.
//  4. MEM_stall=1 for 5 cycles during RESP -> mem_done/MEM_data held constant 5 cycles; IDLE one edge after stall drops.
//  5. Errors: addr=BASE+4*DEPTH, addr=BASE+2, mask 0110 -> mem_done=1, mem_err=1, MEM_data=0, SRAM unchanged on read-back.
//  6. Assert MMU_reset_n in WAIT of write 0x12345678 (WAIT_STATES=2) -> outputs 0 at once, old word remains on read-back.

Source files
------------

// File: rtl/mmu_sram_responder_pkg.sv
// Shared types and constants for the MMU SRAM responder: FSM states,
// read/write encoding and the list of byte-lane masks the responder accepts.
package mmu_sram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mmu_state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Byte, aligned halfword and full-word accesses only.
  localparam int N_LEGAL_MASKS = 7;
  localparam logic [3:0] LEGAL_MASKS [N_LEGAL_MASKS] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
  };

  // True when the mask is one of the supported lane patterns.
  function automatic logic mask_legal(input logic [3:0] mask);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < N_LEGAL_MASKS; i++) begin
      if (mask == LEGAL_MASKS[i]) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/mmu_sram_responder_if.sv
// Request/response bundle between the CU memory stage (master) and the
// MMU SRAM responder (slave).
interface mmu_sram_responder_if;
  logic        memfetch_start;
  logic [31:0] addr;
  logic [3:0]  bits_to_access;
  logic        read_or_write;
  logic [31:0] wdata;
  logic        MEM_stall;
  logic        mem_busy;
  logic        mem_done;
  logic        mem_err;
  logic [31:0] MEM_data;

  modport master (
    output memfetch_start, addr, bits_to_access, read_or_write, wdata, MEM_stall,
    input  mem_busy, mem_done, mem_err, MEM_data
  );

  modport slave (
    input  memfetch_start, addr, bits_to_access, read_or_write, wdata, MEM_stall,
    output mem_busy, mem_done, mem_err, MEM_data
  );
endinterface

// File: rtl/mmu_sram_responder_sram_array.sv
// DEPTH x 32 word array, synchronous read and write with per-byte enables.
// The read register zeroes lanes not selected by the mask and can be cleared
// so it doubles as the responder's read-data output register.
module mmu_sram_array #(
  parameter  int DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             re,
  input  logic             clr,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write into the storage array.
  // NOTE: storage has no reset so it maps onto SRAM macros / RAM blocks;
  // only the small read register below is reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register: masked word on a read, zero when the response retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      for (int i = 0; i < 4; i++) begin
        rdata[8*i +: 8] <= be[i] ? mem[idx][8*i +: 8] : 8'h00;
      end
    end
  end

endmodule

// File: rtl/mmu_sram_responder.sv
// Memory-side responder for CU loads/stores: captures one request, checks
// alignment, range and lane mask, waits WAIT_STATES cycles, performs the
// SRAM access and holds a registered response until the requester takes it.
module mmu_sram_responder
  import mmu_sram_responder_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                 soc_clk,
  input  logic                 MMU_reset_n,
  mmu_sram_responder_if.slave  bus
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  mmu_state_t  state_q, state_d;
  logic [31:0] addr_q;
  logic [3:0]  mask_q;
  logic        rw_q;
  logic [31:0] wdata_q;
  logic [3:0]  cnt_q;
  logic        done_q;
  logic        err_q;

  logic [31:0] offset;
  logic        req_err;
  logic        last_wait;
  logic        resp_exit;
  logic        sram_we;
  logic        sram_re;

  // Offset is taken in 32 bits and range-checked before truncation, so an
  // out-of-range address can never alias onto a valid word.
  assign offset    = addr_q - BASE_ADDR;
  assign req_err   = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) ||
                     (offset >= SPAN) || !mask_legal(mask_q);
  assign last_wait = (state_q == WAIT) && (cnt_q == WS);
  assign resp_exit = (state_q == RESP) && !bus.MEM_stall;
  assign sram_we   = last_wait && (rw_q == RW_WRITE) && !req_err;
  assign sram_re   = last_wait && (rw_q == RW_READ)  && !req_err;

  assign bus.mem_busy = (state_q != IDLE);
  assign bus.mem_done = done_q;
  assign bus.mem_err  = err_q;

  mmu_sram_array #(.DEPTH(DEPTH)) u_array (
    .clk   (soc_clk),
    .rst_n (MMU_reset_n),
    .we    (sram_we),
    .re    (sram_re),
    .clr   (resp_exit),
    .be    (mask_q),
    .idx   (offset[IDX_W+1:2]),
    .wdata (wdata_q),
    .rdata (bus.MEM_data)
  );

  // State register.
  // NOTE: clocked blocks use non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge soc_clk or negedge MMU_reset_n) begin
    if (!MMU_reset_n) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic: one request in flight, starts ignored while busy.
  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.memfetch_start) state_d = WAIT;
      WAIT:    if (cnt_q == WS)        state_d = RESP;
      RESP:    if (!bus.MEM_stall)     state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Request capture, taken only when a start is accepted in IDLE.
  always_ff @(posedge soc_clk or negedge MMU_reset_n) begin
    if (!MMU_reset_n) begin
      addr_q  <= '0;
      mask_q  <= '0;
      rw_q    <= RW_READ;
      wdata_q <= '0;
    end else if (state_q == IDLE && bus.memfetch_start) begin
      addr_q  <= bus.addr;
      mask_q  <= bus.bits_to_access;
      rw_q    <= bus.read_or_write;
      wdata_q <= bus.wdata;
    end
  end

  // Wait-state counter: cleared on accept, counts up to WAIT_STATES in WAIT.
  always_ff @(posedge soc_clk or negedge MMU_reset_n) begin
    if (!MMU_reset_n) begin
      cnt_q <= '0;
    end else if (state_q == IDLE && bus.memfetch_start) begin
      cnt_q <= '0;
    end else if (state_q == WAIT && cnt_q != WS) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // Response flags: raised entering RESP, held under stall, dropped on exit.
  always_ff @(posedge soc_clk or negedge MMU_reset_n) begin
    if (!MMU_reset_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (last_wait) begin
      done_q <= 1'b1;
      err_q  <= req_err;
    end else if (resp_exit) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmu_sram_responder.sv
// Directed bench for mmu_sram_responder. Two instances share a clock:
// dut_a (WAIT_STATES=3) and dut_b (WAIT_STATES=2), both 16 words at 0x1000.
module tb_mmu_sram_responder;
  import mmu_sram_responder_pkg::*;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  mmu_sram_responder_if bus_a ();
  mmu_sram_responder_if bus_b ();

  mmu_sram_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut_a (
    .soc_clk(clk), .MMU_reset_n(rst_n_a), .bus(bus_a.slave));

  mmu_sram_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(2)) dut_b (
    .soc_clk(clk), .MMU_reset_n(rst_n_b), .bus(bus_b.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit sel, input logic start, input logic rw,
                         input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] wdata);
    if (!sel) begin
      bus_a.memfetch_start = start; bus_a.read_or_write = rw; bus_a.addr = addr;
      bus_a.bits_to_access = mask;  bus_a.wdata = wdata;
    end else begin
      bus_b.memfetch_start = start; bus_b.read_or_write = rw; bus_b.addr = addr;
      bus_b.bits_to_access = mask;  bus_b.wdata = wdata;
    end
  endtask

  function automatic logic busy_of(input bit sel);
    return sel ? bus_b.mem_busy : bus_a.mem_busy;
  endfunction
  function automatic logic done_of(input bit sel);
    return sel ? bus_b.mem_done : bus_a.mem_done;
  endfunction
  function automatic logic err_of(input bit sel);
    return sel ? bus_b.mem_err : bus_a.mem_err;
  endfunction
  function automatic logic [31:0] data_of(input bit sel);
    return sel ? bus_b.MEM_data : bus_a.MEM_data;
  endfunction

  // One complete transaction with MEM_stall low; returns response fields.
  task automatic access(input bit sel, input string tag, input logic rw,
                        input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
    bit seen = 1'b0;
    @(negedge clk); set_req(sel, 1'b1, rw, addr, mask, wdata);
    @(negedge clk); set_req(sel, 1'b0, RW_READ, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 40; i++) begin
      if (done_of(sel)) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    rdata = data_of(sel);
    err   = err_of(sel);
    @(negedge clk);
    check({tag, "_idle_after"}, {30'b0, busy_of(sel), done_of(sel)}, 32'd0);
  endtask

  task automatic do_write(input bit sel, input string tag, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] data,
                          input logic exp_err);
    logic [31:0] rd;
    logic        er;
    access(sel, tag, RW_WRITE, addr, mask, data, rd, er);
    check({tag, "_err"},  32'(er), 32'(exp_err));
    check({tag, "_data"}, rd, 32'h0);
  endtask

  task automatic do_read(input bit sel, input string tag, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] exp_data,
                         input logic exp_err);
    logic [31:0] rd;
    logic        er;
    access(sel, tag, RW_READ, addr, mask, 32'h0, rd, er);
    check({tag, "_err"},  32'(er), 32'(exp_err));
    check({tag, "_data"}, rd, exp_data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    set_req(1'b0, 1'b0, RW_READ, 32'h0, 4'h0, 32'h0);
    set_req(1'b1, 1'b0, RW_READ, 32'h0, 4'h0, 32'h0);
    bus_a.MEM_stall = 1'b0;
    bus_b.MEM_stall = 1'b0;
    #1;
    // Reset state
    check("rst_busy_a", 32'(bus_a.mem_busy), 32'd0);
    check("rst_done_a", 32'(bus_a.mem_done), 32'd0);
    check("rst_err_a",  32'(bus_a.mem_err),  32'd0);
    check("rst_data_a", bus_a.MEM_data,      32'd0);
    check("rst_busy_b", 32'(bus_b.mem_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // Full-word write then read
    do_write(1'b0, "t1_wr", BASE + 32'h10, 4'b1111, 32'hDEAD_BEEF, 1'b0);
    do_read (1'b0, "t1_rd", BASE + 32'h10, 4'b1111, 32'hDEAD_BEEF, 1'b0);

    // Partial-lane writes and masked reads
    do_write(1'b0, "t2_wr_b0", BASE + 32'h10, 4'b0001, 32'h0000_00AA, 1'b0);
    do_write(1'b0, "t2_wr_b2", BASE + 32'h10, 4'b0100, 32'h00BB_0000, 1'b0);
    do_read (1'b0, "t2_rd_full", BASE + 32'h10, 4'b1111, 32'hDEBB_BEAA, 1'b0);
    do_read (1'b0, "t2_rd_hi",   BASE + 32'h10, 4'b1100, 32'hDEBB_0000, 1'b0);
    do_read (1'b0, "t2_rd_lo",   BASE + 32'h10, 4'b0011, 32'h0000_BEAA, 1'b0);
    do_read (1'b0, "t2_rd_b3",   BASE + 32'h10, 4'b1000, 32'hDE00_0000, 1'b0);

    // Latency with WAIT_STATES=3 and a start ignored while busy
    do_write(1'b0, "t3_pre", BASE + 32'h14, 4'b1111, 32'h0000_0000, 1'b0);
    @(negedge clk); set_req(1'b0, 1'b1, RW_READ, BASE + 32'h10, 4'b1111, 32'h0);
    @(negedge clk);  // after edge N
    check("t3_busy_n", 32'(bus_a.mem_busy), 32'd1);
    check("t3_done_n", 32'(bus_a.mem_done), 32'd0);
    set_req(1'b0, 1'b1, RW_WRITE, BASE + 32'h14, 4'b1111, 32'h1111_1111);
    @(negedge clk);  // after edge N+1
    set_req(1'b0, 1'b0, RW_READ, 32'h0, 4'h0, 32'h0);
    check("t3_done_n1", 32'(bus_a.mem_done), 32'd0);
    @(negedge clk);
    check("t3_done_n2", 32'(bus_a.mem_done), 32'd0);
    @(negedge clk);
    check("t3_done_n3", 32'(bus_a.mem_done), 32'd0);
    @(negedge clk);
    check("t3_done_n4", 32'(bus_a.mem_done), 32'd1);
    check("t3_err_n4",  32'(bus_a.mem_err),  32'd0);
    check("t3_data_n4", bus_a.MEM_data,      32'hDEBB_BEAA);
    @(negedge clk);
    check("t3_busy_n5", 32'(bus_a.mem_busy), 32'd0);
    check("t3_done_n5", 32'(bus_a.mem_done), 32'd0);
    check("t3_data_n5", bus_a.MEM_data,      32'd0);
    do_read(1'b0, "t3_ignored", BASE + 32'h14, 4'b1111, 32'h0000_0000, 1'b0);

    // Response held under MEM_stall for 5 cycles
    bus_a.MEM_stall = 1'b1;
    @(negedge clk); set_req(1'b0, 1'b1, RW_READ, BASE + 32'h10, 4'b1111, 32'h0);
    @(negedge clk); set_req(1'b0, 1'b0, RW_READ, 32'h0, 4'h0, 32'h0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (bus_a.mem_done) begin seen = 1'b1; break; end
        @(negedge clk);
      end
      check("t4_done_seen", 32'(seen), 32'd1);
    end
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_done", 32'(bus_a.mem_done), 32'd1);
      check("t4_hold_data", bus_a.MEM_data,      32'hDEBB_BEAA);
      check("t4_hold_busy", 32'(bus_a.mem_busy), 32'd1);
      if (k < 4) @(negedge clk);
    end
    bus_a.MEM_stall = 1'b0;
    @(negedge clk);
    check("t4_exit_busy", 32'(bus_a.mem_busy), 32'd0);
    check("t4_exit_done", 32'(bus_a.mem_done), 32'd0);
    check("t4_exit_data", bus_a.MEM_data,      32'd0);

    // Error responses leave the SRAM untouched
    do_write(1'b0, "t5_w0",        BASE,               4'b1111, 32'h0102_0304, 1'b0);
    do_write(1'b0, "t5_oob_hi",    BASE + 32'h40,      4'b1111, 32'h5555_5555, 1'b1);
    do_write(1'b0, "t5_unaligned", BASE + 32'h12,      4'b1111, 32'h6666_6666, 1'b1);
    do_write(1'b0, "t5_mask0110",  BASE + 32'h10,      4'b0110, 32'h7777_7777, 1'b1);
    do_read (1'b0, "t5_mask0000",  BASE + 32'h10,      4'b0000, 32'h0,         1'b1);
    do_write(1'b0, "t5_oob_lo",    BASE - 32'h4,       4'b1111, 32'h8888_8888, 1'b1);
    do_read (1'b0, "t5_rd_unal",   BASE + 32'h12,      4'b1111, 32'h0,         1'b1);
    do_write(1'b0, "t5_last_wr",   BASE + 32'h3C,      4'b1111, 32'hCAFE_F00D, 1'b0);
    do_read (1'b0, "t5_last_rd",   BASE + 32'h3C,      4'b1111, 32'hCAFE_F00D, 1'b0);
    do_read (1'b0, "t5_rb_w4",     BASE + 32'h10,      4'b1111, 32'hDEBB_BEAA, 1'b0);
    do_read (1'b0, "t5_rb_w0",     BASE,               4'b1111, 32'h0102_0304, 1'b0);

    // Reset during WAIT drops the uncommitted write (dut_b, WAIT_STATES=2)
    do_write(1'b1, "t6_pre_wr", BASE + 32'h10, 4'b1111, 32'h0BAD_F00D, 1'b0);
    do_read (1'b1, "t6_pre_rd", BASE + 32'h10, 4'b1111, 32'h0BAD_F00D, 1'b0);
    @(negedge clk); set_req(1'b1, 1'b1, RW_WRITE, BASE + 32'h10, 4'b1111, 32'h1234_5678);
    @(negedge clk); set_req(1'b1, 1'b0, RW_READ, 32'h0, 4'h0, 32'h0);
    check("t6_busy_wait", 32'(bus_b.mem_busy), 32'd1);
    @(negedge clk);
    rst_n_b = 1'b0;
    #1;
    check("t6_rst_busy", 32'(bus_b.mem_busy), 32'd0);
    check("t6_rst_done", 32'(bus_b.mem_done), 32'd0);
    check("t6_rst_err",  32'(bus_b.mem_err),  32'd0);
    check("t6_rst_data", bus_b.MEM_data,      32'd0);
    repeat (3) @(negedge clk);
    rst_n_b = 1'b1;
    do_read(1'b1, "t6_rb", BASE + 32'h10, 4'b1111, 32'h0BAD_F00D, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
